axi_gcd_multi: RTL
==================

Name: axi_gcd_multi

Overview:
- AXI4-lite slave exposing N_CH independent iterative GCD engines of parametrised operand width.
- Adds over the single-channel block: independent AW/W acceptance, sticky DONE with write-1-to-clear, a level interrupt, and SLVERR responses for unmapped or illegal accesses.
- Sits on the PS general-purpose AXI port; software polls status or waits on `irq`.

Parameters:
- N_CH, 4, number of GCD channels (legal range 1..7).
- DATA_W, 32, operand/result width in bits (legal range 8..32); upper bus bits read 0 and are ignored on write.
- ADDR_W, 8, decoded AXI address bits; higher address bits are ignored.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  32  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  32  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- irq  out  1  level interrupt, `|(done & irq_en)`.

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0 and every register clears; on reset deassertion the slave is idle and accepts AW/W.
- Register map, channel c at base c*0x20:
  - +0x00 CTRL: bit0 START (write 1 = launch), bit1 READY (R), bit2 DONE (R, sticky, write 1 to clear).
  - +0x08 A (R/W).
  - +0x10 B (R/W).
  - +0x18 R (R).
  - 0xF0 IRQ_EN: bits[N_CH-1:0] (R/W).
  - 0xF8 IRQ_STAT: bits[N_CH-1:0] = DONE vector (R; write 1 clears the matching DONE).
- Write channel:
  - AW and W are latched independently. awready is high while no address is held; wready is high while no data is held.
  - When both are held, the write is committed in the next cycle, then bvalid is asserted and held until bready.
  - No new AW/W is accepted until the B handshake completes; one write is outstanding at a time.
  - wstrb masks bytes within the DATA_W bits.
- Read channel:
  - arready is high in idle. On the AR handshake, rdata and rresp are registered and rvalid rises the following cycle, then holds until rready.
  - Read latency is 1 cycle from the AR handshake.
- SLVERR cases:
  - Access to an unmapped offset, or to a channel index >= N_CH.
  - Write to A, B or START while that channel is busy.
  - Write to a read-only register, R or IRQ_STAT (a write-1-to-clear to IRQ_STAT is OKAY).
  - An SLVERR write has no effect. An SLVERR read returns 0.
- START:
  - Accepted only when READY=1 and the wdata bit0 is 1.
  - Same-cycle effect: DONE clears and the engine loads A and B.
  - START together with a DONE-clear in the same write: START wins, and DONE is cleared anyway.
- Engine (gcd_engine), states IDLE -> CALC -> IDLE:
  - Load cycle: x <= A, y <= B.
  - Each CALC cycle: if x==y or y==0, result = x, finish. Else if x==0, result = y, finish. Else if x>y, x <= x-y; otherwise y <= y-x.
  - On finish: R is updated, READY rises, DONE is set, all in the same clock edge.
  - gcd(0,0) = 0, finishing after 1 CALC cycle.
  - Latency = 1 + number of subtraction steps + 1 cycles, from the START commit to READY.
- Reads during CALC return the previous R and the live READY. A, B, IRQ_EN and DONE retain their values across a channel's operation.
- Simultaneous events: a DONE set from the engine and a software clear of the same bit in the same cycle leaves DONE=1 (set wins).
- Reset mid-calculation aborts the calculation: READY=1, R=0.

Decomposition:
- Package `axi_gcd_pkg` holds:
  - RESP_OKAY / RESP_SLVERR.
  - Offset constants: CH_STRIDE=0x20, OFF_CTRL, OFF_A, OFF_B, OFF_R, ADDR_IRQ_EN, ADDR_IRQ_STAT.
  - Engine state enum: IDLE, CALC.
- Sub-module `gcd_engine` is parameterised by DATA_W. Ports: aclk, areset, start, a, b, ready, done_pulse, r.
- The top instantiates N_CH copies in a generate loop.

Test Plan:
- Reset -> all outputs 0. CTRL(ch0) read returns 0x2 (READY=1), R=0, irq=0.
- Ch0: A=48, B=18, START -> READY low. After 1+4+1=6 cycles (48,18 → 30,18 → 12,18 → 12,6 → 6,6), R=6, DONE=1. With IRQ_EN=1, irq=1; writing IRQ_STAT=0x1 drops irq.
- Ch1 A=0,B=35 and ch2 A=0,B=0 started back to back -> R1=35, R2=0. Ch3 with A=0xFFFFFFFF, B=1 stays busy. A write to ch3 A while busy -> bresp=10 and A unchanged.
- Write with W presented 3 cycles before AW, plus bready held low 5 cycles -> single commit, bvalid held 5 cycles, no second acceptance during the hold.
- Read 0x80 with N_CH=4, and read 0xE8 -> rresp=10, rdata=0. Write to R -> SLVERR, R unchanged. wstrb=0x1 write of 0xAABBCCDD to A=0 -> A=0x000000DD.
- Assert areset during ch0 CALC -> READY=1, R=0, DONE=0, irq=0. A fresh START after release completes correctly.

Source files
------------

// File: rtl/axi_gcd_multi_pkg.sv
// Shared constants, address decode and engine state type for the multi-channel GCD slave.
package axi_gcd_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] CH_STRIDE     = 8'h20;
  localparam logic [4:0] OFF_CTRL      = 5'h00;
  localparam logic [4:0] OFF_A         = 5'h08;
  localparam logic [4:0] OFF_B         = 5'h10;
  localparam logic [4:0] OFF_R         = 5'h18;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'hF0;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'hF8;

  typedef enum logic {IDLE, CALC} gcd_state_e;

  typedef struct packed {
    logic       irq_en;
    logic       irq_stat;
    logic       ch_ok;
    logic [2:0] ch;
    logic [4:0] sub;
  } addr_dec_t;

  // Channel windows occupy 0x00..0xDF at most (N_CH <= 7), so the global
  // registers in the top 0x20 never alias a live channel.
  function automatic addr_dec_t addr_decode(input logic [31:0] off, input int n_ch);
    addr_dec_t d;
    d.ch       = off[7:5];
    d.sub      = off[4:0];
    d.irq_en   = (off == 32'(ADDR_IRQ_EN));
    d.irq_stat = (off == 32'(ADDR_IRQ_STAT));
    d.ch_ok    = (off[31:8] == '0) && (off[2:0] == 3'b000) && (int'(off[7:5]) < n_ch);
    return d;
  endfunction

endpackage

// File: rtl/axi_gcd_multi_if.sv
// AXI4-lite bus bundle between the PS master and the GCD slave.
interface axi_gcd_multi_if;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi_gcd_multi_gcd_engine.sv
// Iterative subtract-only GCD engine; one subtraction per CALC cycle.
module gcd_engine
  import axi_gcd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              ready,
  output logic              done_pulse,
  output logic [DATA_W-1:0] r
);

  gcd_state_e        state_q;
  logic [DATA_W-1:0] x_q, y_q, r_q;
  logic              ready_q;

  // Combinational so the owner can set DONE on the same edge READY rises.
  assign done_pulse = (state_q == CALC) && ((x_q == y_q) || (y_q == '0) || (x_q == '0));
  assign ready      = ready_q;
  assign r          = r_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          x_q     <= a;
          y_q     <= b;
          ready_q <= 1'b0;
          state_q <= CALC;
        end
        CALC: begin
          if ((x_q == y_q) || (y_q == '0)) begin
            r_q     <= x_q;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (x_q == '0) begin
            r_q     <= y_q;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (x_q > y_q) begin
            x_q <= x_q - y_q;
          end else begin
            y_q <= y_q - x_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_gcd_multi.sv
// AXI4-lite slave fronting N_CH GCD engines with sticky DONE, W1C and a level irq.
module axi_gcd_multi
  import axi_gcd_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic             aclk,
  input  logic             areset,
  axi_gcd_multi_if.slave   s_axi,
  output logic             irq
);

  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [N_CH-1:0][DATA_W-1:0] a_q, a_d, b_q, b_d, r;
  logic [N_CH-1:0] irq_en_q, irq_en_d, done_q, done_d;
  logic [N_CH-1:0] ready, done_pulse, start, done_clr;

  logic        aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;
  logic [31:0] mask32, wd_m, rd_val;
  addr_dec_t   wdec, rdec;
  logic        unused_addr;

  assign unused_addr = ^{s_axi.s_axi_awaddr[31:ADDR_W], s_axi.s_axi_araddr[31:ADDR_W]};

  // Readies are forced low during reset so every output reads 0 then.
  assign s_axi.s_axi_awready = ~aw_held_q & ~bvalid_q & ~areset;
  assign s_axi.s_axi_wready  = ~w_held_q & ~bvalid_q & ~areset;
  assign s_axi.s_axi_arready = ~rvalid_q & ~areset;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;
  assign irq                 = |(done_q & irq_en_q);

  assign aw_hs  = s_axi.s_axi_awvalid & s_axi.s_axi_awready;
  assign w_hs   = s_axi.s_axi_wvalid & s_axi.s_axi_wready;
  assign ar_hs  = s_axi.s_axi_arvalid & s_axi.s_axi_arready;
  assign commit = aw_held_q & w_held_q;

  assign wdec = addr_decode(32'(awaddr_q), N_CH);
  assign rdec = addr_decode(32'(s_axi.s_axi_araddr[ADDR_W-1:0]), N_CH);

  always_comb begin
    for (int i = 0; i < 4; i++) mask32[i*8 +: 8] = {8{wstrb_q[i]}};
  end
  assign wd_m = wdata_q & mask32;

  // Register-file write decode; effects are discarded unless the write commits.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    irq_en_d = irq_en_q;
    start    = '0;
    done_clr = '0;
    wr_err   = 1'b1;
    if (wdec.irq_en) begin
      wr_err   = 1'b0;
      irq_en_d = (irq_en_q & ~mask32[N_CH-1:0]) | wd_m[N_CH-1:0];
    end
    if (wdec.irq_stat) begin
      wr_err   = 1'b0;
      done_clr = wd_m[N_CH-1:0];
    end
    for (int i = 0; i < N_CH; i++) begin
      if (wdec.ch_ok && (wdec.ch == 3'(i))) begin
        case (wdec.sub)
          OFF_CTRL: if (!(wd_m[0] && !ready[i])) begin
            wr_err      = 1'b0;
            start[i]    = wd_m[0];
            done_clr[i] = wd_m[0] | wd_m[2];
          end
          OFF_A: if (ready[i]) begin
            wr_err = 1'b0;
            a_d[i] = (a_q[i] & ~mask32[DATA_W-1:0]) | wd_m[DATA_W-1:0];
          end
          OFF_B: if (ready[i]) begin
            wr_err = 1'b0;
            b_d[i] = (b_q[i] & ~mask32[DATA_W-1:0]) | wd_m[DATA_W-1:0];
          end
          default: ;
        endcase
      end
    end
    if (!commit) begin
      a_d      = a_q;
      b_d      = b_q;
      irq_en_d = irq_en_q;
      start    = '0;
      done_clr = '0;
    end
  end

  // Engine completion beats a same-cycle software clear.
  assign done_d = (done_q & ~done_clr) | done_pulse;

  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    if (rdec.irq_en) begin
      rd_val = 32'(irq_en_q);
      rd_err = 1'b0;
    end
    if (rdec.irq_stat) begin
      rd_val = 32'(done_q);
      rd_err = 1'b0;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (rdec.ch_ok && (rdec.ch == 3'(i))) begin
        rd_err = 1'b0;
        case (rdec.sub)
          OFF_CTRL: rd_val = 32'({done_q[i], ready[i], 1'b0});
          OFF_A:    rd_val = 32'(a_q[i]);
          OFF_B:    rd_val = 32'(b_q[i]);
          OFF_R:    rd_val = 32'(r[i]);
          default:  rd_err = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi.s_axi_awaddr[ADDR_W-1:0];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.s_axi_wdata;
      wstrb_d  = s_axi.s_axi_wstrb;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q && s_axi.s_axi_bready) begin
      bvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && s_axi.s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      irq_en_q  <= '0;
      done_q    <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      a_q       <= a_d;
      b_q       <= b_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    gcd_engine #(.DATA_W(DATA_W)) u_eng (
      .aclk       (aclk),
      .areset     (areset),
      .start      (start[g]),
      .a          (a_q[g]),
      .b          (b_q[g]),
      .ready      (ready[g]),
      .done_pulse (done_pulse[g]),
      .r          (r[g])
    );
  end

endmodule
